// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: loader states,
// the fetch value presented while the core is held off, and stream framing sizes.
package imem_boot_loader_pkg;

   typedef enum logic [1:0] {
      CNT_LO = 2'd0,
      CNT_HI = 2'd1,
      WORDS  = 2'd2,
      RUN    = 2'd3
   } state_e;

   // addi x0,x0,0 -- harmless filler while the program is not yet loaded
   localparam logic [31:0] NOP_INSTR_C    = 32'h0000_0013;
   localparam int          HDR_BYTES      = 2;
   localparam int          BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_boot_loader_array.sv
// Instruction RAM: synchronous write from the loader, asynchronous read for
// the single-cycle core's zero-latency fetch. Contents survive reset.
module imem_boot_loader_array #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [31:0]       wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [31:0]       rdata
);

   logic [31:0] mem [2**ADDR_W];

   // Write port: one word per cycle, no reset so loaded code persists
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: parses a length-prefixed little-endian byte stream into the
// instruction RAM, holds the core in reset until the load finishes, then
// serves combinational fetch on PC/Instr.
module imem_boot_loader
   import imem_boot_loader_pkg::*;
#(
   parameter int          ADDR_W    = 8,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   input  logic [31:0] PC,
   output logic [31:0] Instr,
   output logic        core_rst_n,
   output logic        load_done,
   output logic        load_err
);

   localparam logic [31:0] DEPTH = 32'(2**ADDR_W);

   state_e      state_q, state_d;
   logic [15:0] count_q, count_d;
   logic [15:0] word_idx_q, word_idx_d;
   logic [1:0]  byte_idx_q, byte_idx_d;
   logic [31:0] asm_q, asm_d;
   logic        err_q, err_d;

   logic              accept;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [31:0]       wdata;
   logic [31:0]       rdata;
   logic [15:0]       hdr_count;
   logic              pc_unused;

   assign rx_ready  = (state_q != RUN);
   assign accept    = rx_valid && rx_ready;
   assign hdr_count = {rx_data, count_q[7:0]};
   // Byte 0 lands in bits [7:0], so the assembly register shifts right
   assign wdata     = {rx_data, asm_q[31:8]};
   assign waddr     = word_idx_q[ADDR_W-1:0];

   // State and datapath registers, all cleared by the asynchronous reset
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= CNT_LO;
         count_q    <= '0;
         word_idx_q <= '0;
         byte_idx_q <= '0;
         asm_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         word_idx_q <= word_idx_d;
         byte_idx_q <= byte_idx_d;
         asm_q      <= asm_d;
         err_q      <= err_d;
      end
   end

   // Stream parser: header count, then word assembly and RAM writes
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      word_idx_d = word_idx_q;
      byte_idx_d = byte_idx_q;
      asm_d      = asm_q;
      err_d      = err_q;
      we         = 1'b0;
      case (state_q)
         CNT_LO: begin
            if (accept) begin
               count_d[7:0] = rx_data;
               state_d      = CNT_HI;
            end
         end
         CNT_HI: begin
            if (accept) begin
               count_d[15:8] = rx_data;
               word_idx_d    = '0;
               byte_idx_d    = '0;
               state_d       = (hdr_count == 16'd0) ? RUN : WORDS;
               // Oversized images still stream through; excess words are dropped
               if (32'(hdr_count) > DEPTH) begin
                  err_d = 1'b1;
               end
            end
         end
         WORDS: begin
            if (accept) begin
               asm_d      = wdata;
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'(BYTES_PER_WORD - 1)) begin
                  we         = (32'(word_idx_q) < DEPTH);
                  word_idx_d = word_idx_q + 16'd1;
                  if (word_idx_q == count_q - 16'd1) begin
                     state_d = RUN;
                  end
               end
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   imem_boot_loader_array #(
      .ADDR_W(ADDR_W)
   ) u_array (
      .clk  (CLK),
      .we   (we),
      .waddr(waddr),
      .wdata(wdata),
      .raddr(PC[ADDR_W+1:2]),
      .rdata(rdata)
   );

   // Byte offset and high PC bits alias onto the same words
   assign pc_unused  = ^{PC[31:ADDR_W+2], PC[1:0]};

   assign Instr      = (state_q == RUN) ? rdata : NOP_INSTR;
   assign core_rst_n = (state_q == RUN);
   assign load_done  = (state_q == RUN);
   assign load_err   = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for the boot loader: directed byte streams on a full-size instance and
// a 4-word instance; expectations queued by stimulus, checked by a monitor.
module tb_imem_boot_loader;
   import imem_boot_loader_pkg::*;

   typedef enum int {SIG_INSTR, SIG_CRST, SIG_DONE, SIG_ERR, SIG_RDY} sig_e;
   typedef struct {
      int          inst;
      sig_e        sig;
      logic [31:0] val;
      string       name;
   } exp_t;

   logic        CLK;
   logic        RST;
   logic        a_valid, b_valid;
   logic [7:0]  a_data, b_data;
   logic        a_ready, b_ready;
   logic [31:0] a_pc, b_pc;
   logic [31:0] a_instr, b_instr;
   logic        a_crst, b_crst;
   logic        a_done, b_done;
   logic        a_err, b_err;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   imem_boot_loader #(.ADDR_W(8)) dut_a (
      .CLK(CLK), .RST(RST), .rx_valid(a_valid), .rx_data(a_data), .rx_ready(a_ready),
      .PC(a_pc), .Instr(a_instr), .core_rst_n(a_crst), .load_done(a_done), .load_err(a_err)
   );

   imem_boot_loader #(.ADDR_W(2)) dut_b (
      .CLK(CLK), .RST(RST), .rx_valid(b_valid), .rx_data(b_data), .rx_ready(b_ready),
      .PC(b_pc), .Instr(b_instr), .core_rst_n(b_crst), .load_done(b_done), .load_err(b_err)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic logic [31:0] get_sig(input int inst, input sig_e s);
      logic [31:0] r;
      r = 32'hDEAD_DEAD;
      case (s)
         SIG_INSTR: r = (inst == 0) ? a_instr : b_instr;
         SIG_CRST:  r = {31'd0, (inst == 0) ? a_crst : b_crst};
         SIG_DONE:  r = {31'd0, (inst == 0) ? a_done : b_done};
         SIG_ERR:   r = {31'd0, (inst == 0) ? a_err : b_err};
         SIG_RDY:   r = {31'd0, (inst == 0) ? a_ready : b_ready};
         default:   r = 32'hDEAD_DEAD;
      endcase
      return r;
   endfunction

   // Monitor: compare every queued expectation at the falling edge
   always @(negedge CLK) begin
      while (sb.size() > 0) begin
         exp_t        e;
         logic [31:0] act;
         e   = sb.pop_front();
         act = get_sig(e.inst, e.sig);
         checks++;
         if (act !== e.val) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.val);
         end
      end
   end

   task automatic expect_sig(input int inst, input sig_e s, input logic [31:0] v, input string nm);
      exp_t e;
      e.inst = inst;
      e.sig  = s;
      e.val  = v;
      e.name = nm;
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic send(input int inst, input logic [7:0] b);
      if (inst == 0) begin
         a_valid = 1'b1;
         a_data  = b;
      end else begin
         b_valid = 1'b1;
         b_data  = b;
      end
      @(posedge CLK);
      #1;
      a_valid = 1'b0;
      b_valid = 1'b0;
   endtask

   task automatic fetch(input int inst, input logic [31:0] pc, input logic [31:0] v, input string nm);
      if (inst == 0) a_pc = pc;
      else           b_pc = pc;
      expect_sig(inst, SIG_INSTR, v, nm);
      idle(1);
   endtask

   task automatic do_reset(input string nm);
      RST  = 1'b0;
      a_pc = 32'h0;
      expect_sig(0, SIG_CRST, 32'd0, {nm, "_crst"});
      expect_sig(0, SIG_DONE, 32'd0, {nm, "_done"});
      expect_sig(0, SIG_RDY,  32'd1, {nm, "_rdy"});
      expect_sig(0, SIG_ERR,  32'd0, {nm, "_err"});
      expect_sig(0, SIG_INSTR, NOP_INSTR_C, {nm, "_nop"});
      expect_sig(1, SIG_CRST, 32'd0, {nm, "_b_crst"});
      expect_sig(1, SIG_ERR,  32'd0, {nm, "_b_err"});
      idle(1);
      RST = 1'b1;
      idle(1);
   endtask

   initial begin
      RST     = 1'b1;
      a_valid = 1'b0;
      b_valid = 1'b0;
      a_data  = 8'h00;
      b_data  = 8'h00;
      a_pc    = 32'h0;
      b_pc    = 32'h0;
      #2;
      RST = 1'b0;
      @(posedge CLK);
      #1;
      do_reset("reset");

      // Two-word program with idle gaps between bytes
      send(0, 8'h02);
      idle(2);
      send(0, 8'h00);
      send(0, 8'h13);
      send(0, 8'h05);
      idle(1);
      send(0, 8'h10);
      send(0, 8'h00);
      a_pc = 32'h8;
      expect_sig(0, SIG_INSTR, NOP_INSTR_C, "nop_during_load");
      send(0, 8'hB3);
      idle(3);
      send(0, 8'h05);
      send(0, 8'hB5);
      expect_sig(0, SIG_CRST, 32'd0, "crst_before_last");
      send(0, 8'h00);
      expect_sig(0, SIG_CRST, 32'd1, "crst_after_last");
      expect_sig(0, SIG_DONE, 32'd1, "done_after_last");
      expect_sig(0, SIG_RDY,  32'd0, "rdy_in_run");
      expect_sig(0, SIG_ERR,  32'd0, "err_clean_load");
      idle(1);
      fetch(0, 32'h0000_0000, 32'h0010_0513, "fetch_pc0");
      fetch(0, 32'h0000_0004, 32'h00B5_05B3, "fetch_pc4");
      fetch(0, 32'h0000_0006, 32'h00B5_05B3, "fetch_pc6");
      fetch(0, 32'h0000_0404, 32'h00B5_05B3, "fetch_alias");

      // Bytes offered in RUN are refused and leave memory untouched
      a_pc = 32'h0;
      expect_sig(0, SIG_RDY, 32'd0, "run_rdy_while_valid");
      send(0, 8'hAA);
      send(0, 8'hBB);
      send(0, 8'hCC);
      send(0, 8'hDD);
      fetch(0, 32'h0000_0000, 32'h0010_0513, "run_bytes_pc0");
      fetch(0, 32'h0000_0004, 32'h00B5_05B3, "run_bytes_pc4");

      // Reset in the middle of word 1, then a fresh one-word load
      do_reset("rst_pre");
      send(0, 8'h02);
      send(0, 8'h00);
      send(0, 8'h11);
      send(0, 8'h22);
      send(0, 8'h33);
      send(0, 8'h44);
      send(0, 8'h55);
      do_reset("rst_mid");
      send(0, 8'h01);
      send(0, 8'h00);
      send(0, 8'hEF);
      send(0, 8'hBE);
      send(0, 8'hAD);
      expect_sig(0, SIG_DONE, 32'd0, "reload_done_early");
      send(0, 8'hDE);
      expect_sig(0, SIG_DONE, 32'd1, "reload_done");
      idle(1);
      fetch(0, 32'h0000_0000, 32'hDEAD_BEEF, "reload_pc0");
      fetch(0, 32'h0000_0004, 32'h00B5_05B3, "reload_pc4_retained");

      // Empty image goes straight to RUN
      do_reset("rst_empty");
      send(0, 8'h00);
      expect_sig(0, SIG_DONE, 32'd0, "empty_done_early");
      send(0, 8'h00);
      expect_sig(0, SIG_DONE, 32'd1, "empty_done");
      expect_sig(0, SIG_CRST, 32'd1, "empty_crst");
      expect_sig(0, SIG_RDY,  32'd0, "empty_rdy");
      expect_sig(0, SIG_ERR,  32'd0, "empty_err");
      idle(1);
      fetch(0, 32'h0000_0000, 32'hDEAD_BEEF, "empty_pc0_retained");

      // Oversized header on the 4-word instance
      do_reset("rst_ovf");
      b_pc = 32'h0;
      send(1, 8'h05);
      expect_sig(1, SIG_ERR, 32'd0, "ovf_err_early");
      for (int i = 1; i < HDR_BYTES; i++) send(1, 8'h00);
      expect_sig(1, SIG_ERR,   32'd1, "ovf_err_set");
      expect_sig(1, SIG_INSTR, NOP_INSTR_C, "ovf_nop");
      for (int w = 0; w < 5; w++) begin
         send(1, 8'(w + 1));
         send(1, 8'hA0);
         send(1, 8'hB0);
         if (w == 4) expect_sig(1, SIG_CRST, 32'd0, "ovf_crst_byte21");
         send(1, 8'hC0);
      end
      expect_sig(1, SIG_CRST, 32'd1, "ovf_crst_byte22");
      expect_sig(1, SIG_DONE, 32'd1, "ovf_done");
      expect_sig(1, SIG_ERR,  32'd1, "ovf_err_sticky");
      idle(1);
      fetch(1, 32'h0000_0000, 32'hC0B0_A001, "ovf_pc0_kept");
      fetch(1, 32'h0000_0004, 32'hC0B0_A002, "ovf_pc4");
      fetch(1, 32'h0000_0008, 32'hC0B0_A003, "ovf_pc8");
      fetch(1, 32'h0000_000C, 32'hC0B0_A004, "ovf_pcC");
      fetch(1, 32'h0000_0010, 32'hC0B0_A001, "ovf_wrap");

      idle(2);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Upstream feeder for the single-cycle RV32I core: owns the instruction memory, fills it from a byte stream after reset, holds the core in reset while loading, then serves combinational instruction fetch on the core's PC/Instr pair. Replaces a hard-coded ROM so programs can be loaded at bring-up without resynthesis.

## Interface
- ADDR_W, 8: word-address width; memory depth = 2**ADDR_W 32-bit words
- NOP_INSTR, 32'h00000013: value returned on Instr while not in RUN (addi x0,x0,0)
- CLK  in  1  system clock, rising-edge
- RST  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- rx_valid  in  1  byte on rx_data is valid
- rx_data  in  8  stream byte
- rx_ready  out  1  loader accepts a byte this cycle
- PC  in  32  core fetch address (byte address)
- Instr  out  32  instruction to core
- core_rst_n  out  1  active-low reset to core; 0 until load complete
- load_done  out  1  high in RUN
- load_err  out  1  sticky: header count exceeded depth

## Operation
- Stream format: 2-byte little-endian word count N, then N words, each 4 bytes little-endian (byte 0 = Instr[7:0]).
- Byte accepted on a rising edge when rx_valid && rx_ready; rx_valid without rx_ready is ignored (no buffering).
- States: CNT_LO -> CNT_HI -> WORDS -> RUN.
  - CNT_LO: accept byte into count[7:0] -> CNT_HI.
  - CNT_HI: accept byte into count[15:8]; if full count == 0 -> RUN, else -> WORDS; word index and byte index cleared.
  - WORDS: shift bytes into 32-bit assembly register; on 4th byte write assembled word to mem[word_idx[ADDR_W-1:0]] if word_idx < 2**ADDR_W, else discard; increment word_idx; when word_idx reaches count-1 on that 4th byte -> RUN.
  - RUN: terminal until RST; rx_ready = 0, incoming bytes ignored.
- rx_ready = 1 in CNT_LO, CNT_HI, WORDS.
- load_err set on the edge leaving CNT_HI when count > 2**ADDR_W; loading continues (excess words consumed and dropped); cleared only by RST.
- Fetch: in RUN, Instr = mem[PC[ADDR_W+1:2]] combinationally; PC[1:0] and PC[31:ADDR_W+2] ignored (aliasing/wrap). Outside RUN, Instr = NOP_INSTR.
- Memory array is not cleared by reset; unwritten words return prior contents (X in simulation).

## Timing
- Reset values: state CNT_LO, rx_ready 1, core_rst_n 0, load_done 0, load_err 0, counters 0, assembly register 0.
- RST low mid-load: immediate return to CNT_LO, core_rst_n 0; already-written words retained but core sees NOP until next full load.
- core_rst_n and load_done are decoded directly from the state flop (no combinational path from rx_*); both rise in the cycle after the edge accepting the final byte (or the CNT_HI byte when N = 0).
- Memory write latency: word readable on Instr from the cycle after its 4th-byte edge (only observable in RUN).
- Instr path PC -> Instr is purely combinational, zero-cycle, as required by the single-cycle core.
- Throughput: one byte per cycle; load of N words takes 2 + 4N accepted bytes.

## Structure
- Shared package: state enum (CNT_LO, CNT_HI, WORDS, RUN), NOP_INSTR constant, header length (2 bytes), bytes-per-word (4).
- One sub-module: imem_array — 2**ADDR_W x 32 RAM, synchronous write port (we, waddr, wdata), asynchronous read port (raddr, rdata); no reset.
- Top holds FSM, byte/word counters, assembly shift register, error flag, Instr mux.

## Test plan
- Reset, stream 02 00, then 13 05 10 00, B3 05 B5 00 -> core_rst_n rises 1 cycle after last byte; PC=0 gives 32'h00100513, PC=4 gives 32'h00B505B3, PC=6 gives 32'h00B505B3.
- Header 00 00 -> RUN one cycle after 2nd byte, load_done=1, rx_ready=0, load_err=0.
- rx_valid toggled with gaps between bytes -> identical memory contents; before RUN Instr = 32'h00000013 for any PC.
- ADDR_W=2, header 05 00 plus 5 words -> load_err=1 after header; 5th word dropped, mem[0] keeps word 0; RUN after 22nd byte.
- RST pulsed low after 1st byte of word 1 -> core_rst_n=0 immediately, state CNT_LO; fresh full load completes normally with new contents.
- Bytes driven in RUN -> rx_ready=0, memory and Instr unchanged.
